// File: rtl/clkdet_scan_ctrl_if.sv
// Bus bundle for clkdet_scan_ctrl.
//   master : scan-policy side (enable, mask, loss clear) plus the detector
//            cell outputs; observes all status.
//   slave  : the scan controller itself.
// Signals:
//   EN        scan enable
//   CH_MASK   1 = channel monitored
//   DET_Q     detector cell outputs (asynchronous to CLK)
//   LOSS_CLR  per-channel clear of sticky LOSS
//   DET_RST   active-high reset to each detector cell
//   CLK_OK    channel currently judged running
//   LOSS      sticky loss flag
//   EVT       one-cycle pulse when a channel drops out of CLK_OK
//   BUSY      scan in progress
//   CUR_CH    channel under test
interface clkdet_scan_ctrl_if #(
  parameter int NCH = 4
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           EN;
  logic [NCH-1:0] CH_MASK;
  logic [NCH-1:0] DET_Q;
  logic [NCH-1:0] LOSS_CLR;
  logic [NCH-1:0] DET_RST;
  logic [NCH-1:0] CLK_OK;
  logic [NCH-1:0] LOSS;
  logic           EVT;
  logic           BUSY;
  logic [CW-1:0]  CUR_CH;

  modport master (
    output EN, CH_MASK, DET_Q, LOSS_CLR,
    input  DET_RST, CLK_OK, LOSS, EVT, BUSY, CUR_CH
  );

  modport slave (
    input  EN, CH_MASK, DET_Q, LOSS_CLR,
    output DET_RST, CLK_OK, LOSS, EVT, BUSY, CUR_CH
  );
endinterface

// File: rtl/clkdet_scan_ctrl.sv
// clkdet_scan_ctrl: round-robin clock-detector scanner.
// Visits each monitored channel in turn: holds its detector cell in reset
// (ARM), releases it for WINDOW cycles (WAIT), samples the synchronized
// detector output (SAMPLE) and then picks the next channel (NEXT).
// Per-channel status (sync, miss debounce, CLK_OK, sticky LOSS) lives in
// one clkdet_lane instance per channel.
// Ports:
//   CLK  supervisory clock, rising edge
//   RST  asynchronous active-low reset
//   bus  clkdet_scan_ctrl_if.slave (see interface header)

// Per-channel status lane.
//   det_q  raw detector output      mon  channel is in the mask
//   smp    this channel is sampled  clr  sticky loss clear
//   clk_ok / loss  status           fall CLK_OK drops this cycle
module clkdet_lane #(
  parameter int MISS_LIM = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic det_q,
  input  logic mon,
  input  logic smp,
  input  logic clr,
  output logic clk_ok,
  output logic loss,
  output logic fall
);
  localparam int MW = 4;

  logic [1:0]    sync;
  logic [MW-1:0] miss, miss_n;
  logic          hit, lose;

  assign hit    = sync[1];
  // Miss count saturates at the limit, so an unrecovered channel keeps
  // re-asserting LOSS on every further miss.
  assign miss_n = (miss == MW'(MISS_LIM)) ? miss : miss + 1'b1;
  assign lose   = smp && !hit && (miss_n == MW'(MISS_LIM));
  assign fall   = lose && clk_ok;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync   <= '0;
      miss   <= '0;
      clk_ok <= 1'b0;
      loss   <= 1'b0;
    end else begin
      sync <= {sync[0], det_q};
      if (!mon) begin
        miss   <= '0;
        clk_ok <= 1'b0;
      end else if (smp) begin
        if (hit) begin
          miss   <= '0;
          clk_ok <= 1'b1;
        end else begin
          miss <= miss_n;
          if (lose) clk_ok <= 1'b0;
        end
      end
      // set beats clear in the same cycle
      if (lose)     loss <= 1'b1;
      else if (clr) loss <= 1'b0;
    end
  end
endmodule

module clkdet_scan_ctrl #(
  parameter int NCH      = 4,
  parameter int WINDOW   = 64,
  parameter int MISS_LIM = 3,
  parameter int RST_CYC  = 2
) (
  input  logic               CLK,
  input  logic               RST,
  clkdet_scan_ctrl_if.slave  bus
);
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNTW = $clog2(WINDOW + RST_CYC + 1);

  typedef enum logic [2:0] {IDLE, ARM, WAIT, SAMPLE, NEXT} state_t;

  state_t          state, state_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [CW-1:0]   cur_ch, cur_n;
  logic            evt;
  logic            cur_mon, smp_v;
  logic [NCH-1:0]  det_rst, smp, clk_ok, loss, fall;

  // Lowest set mask bit at or above start, wrapping; start == NCH means
  // "wrap to the bottom".
  function automatic logic [CW-1:0] pick(input logic [NCH-1:0] m,
                                         input logic [CW:0]    start);
    logic [CW-1:0] r_any, r_hi;
    logic          hi;
    r_any = '0;
    r_hi  = '0;
    hi    = 1'b0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (m[j]) begin
        r_any = CW'(j);
        if (j >= int'(start)) begin
          r_hi = CW'(j);
          hi   = 1'b1;
        end
      end
    end
    return hi ? r_hi : r_any;
  endfunction

  assign cur_mon = bus.CH_MASK[cur_ch];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      cnt    <= '0;
      cur_ch <= '0;
      evt    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      cur_ch <= cur_n;
      evt    <= |fall;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    cur_n   = cur_ch;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.EN && |bus.CH_MASK) begin
          state_n = ARM;
          cur_n   = pick(bus.CH_MASK, {1'b0, cur_ch});
        end
      end
      ARM, WAIT, SAMPLE: begin
        if (!bus.EN) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!cur_mon) begin
          state_n = NEXT;
          cnt_n   = '0;
        end else if (state == ARM) begin
          if (cnt == CNTW'(RST_CYC - 1)) begin
            state_n = WAIT;
            cnt_n   = '0;
          end
        end else if (state == WAIT) begin
          if (cnt == CNTW'(WINDOW - 1)) begin
            state_n = SAMPLE;
            cnt_n   = '0;
          end
        end else begin
          state_n = NEXT;
          cnt_n   = '0;
        end
      end
      NEXT: begin
        cnt_n = '0;
        if (|bus.CH_MASK) cur_n = pick(bus.CH_MASK, {1'b0, cur_ch} + 1'b1);
        state_n = (bus.EN && |bus.CH_MASK) ? ARM : IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Only the channel under test is released, and only during WAIT/SAMPLE.
  assign smp_v = (state == SAMPLE) && bus.EN && cur_mon;

  always_comb begin
    det_rst = '1;
    smp     = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cur_ch == CW'(i)) begin
        det_rst[i] = !((state == WAIT) || (state == SAMPLE));
        smp[i]     = smp_v;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    clkdet_lane #(.MISS_LIM(MISS_LIM)) u_lane (
      .CLK    (CLK),
      .RST    (RST),
      .det_q  (bus.DET_Q[i]),
      .mon    (bus.CH_MASK[i]),
      .smp    (smp[i]),
      .clr    (bus.LOSS_CLR[i]),
      .clk_ok (clk_ok[i]),
      .loss   (loss[i]),
      .fall   (fall[i])
    );
  end

  assign bus.DET_RST = det_rst;
  assign bus.CLK_OK  = clk_ok;
  assign bus.LOSS    = loss;
  assign bus.EVT     = evt;
  assign bus.BUSY    = (state != IDLE);
  assign bus.CUR_CH  = cur_ch;
endmodule

// File: tb/tb_clkdet_scan_ctrl.sv
// Directed bench for clkdet_scan_ctrl (NCH=4, WINDOW=16, MISS_LIM=3,
// RST_CYC=2). Each detector cell is modelled as a flop set by its own
// gated monitored clock and cleared by DET_RST; a stale override can hold
// DET_Q high to emulate a detector left set from an earlier window.
module tb_clkdet_scan_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [3:0] run   = 4'b1111;
  logic [3:0] stale = 4'b0000;
  logic [3:0] det;
  int errors = 0;
  int checks = 0;

  clkdet_scan_ctrl_if #(.NCH(4)) bus ();

  clkdet_scan_ctrl #(.NCH(4), .WINDOW(16), .MISS_LIM(3), .RST_CYC(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  for (genvar i = 0; i < 4; i++) begin : g_det
    logic mclk = 1'b0;
    logic q = 1'b0;
    always #(3 + i) if (run[i]) mclk = ~mclk;
    always @(posedge mclk or posedge bus.DET_RST[i])
      if (bus.DET_RST[i]) q <= 1'b0;
      else                q <= 1'b1;
    assign det[i] = q;
  end

  assign bus.DET_Q = det | stale;

  task automatic test_reset();
    bus.EN = 1'b0; bus.CH_MASK = 4'b0000; bus.LOSS_CLR = 4'b0000;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (bus.DET_RST !== 4'b1111) begin errors++; $display("FAIL reset_det_rst got %b want 1111", bus.DET_RST); end
    checks++; if (bus.CLK_OK !== 4'b0000) begin errors++; $display("FAIL reset_clk_ok got %b want 0000", bus.CLK_OK); end
    checks++; if (bus.LOSS !== 4'b0000) begin errors++; $display("FAIL reset_loss got %b want 0000", bus.LOSS); end
    checks++; if (bus.EVT !== 1'b0 || bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_evt_busy got %b%b want 00", bus.EVT, bus.BUSY); end
    checks++; if (bus.CUR_CH !== 2'd0) begin errors++; $display("FAIL reset_cur_ch got %0d want 0", bus.CUR_CH); end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_round();
    logic [1:0] expseq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] prev;
    int low [4] = '{0, 0, 0, 0};
    int cyc = 0, last = 0, nchg = 0, multi = 0;
    bus.EN = 1'b1; bus.CH_MASK = 4'b1111;
    prev = bus.CUR_CH;
    while (nchg < 4 && cyc < 200) begin
      @(negedge CLK); cyc++;
      if (bus.CUR_CH !== prev) begin
        checks++; if (bus.CUR_CH !== expseq[nchg]) begin errors++; $display("FAIL round_seq got %0d want %0d", bus.CUR_CH, expseq[nchg]); end
        if (nchg > 0) begin
          checks++; if (cyc - last != 20) begin errors++; $display("FAIL round_period got %0d want 20", cyc - last); end
        end
        last = cyc; nchg++; prev = bus.CUR_CH;
      end
      if ($countones(~bus.DET_RST) > 1) multi++;
      if (nchg >= 1 && nchg < 4)
        for (int j = 0; j < 4; j++) if (!bus.DET_RST[j]) low[j]++;
    end
    checks++; if (nchg != 4) begin errors++; $display("FAIL round_timeout got %0d changes want 4", nchg); end
    for (int j = 1; j < 4; j++) begin
      checks++; if (low[j] != 17) begin errors++; $display("FAIL round_det_rst_low ch%0d got %0d want 17", j, low[j]); end
    end
    checks++; if (multi != 0) begin errors++; $display("FAIL round_one_released got %0d bad cycles want 0", multi); end
    checks++; if (bus.CLK_OK !== 4'b1111) begin errors++; $display("FAIL round_clk_ok got %b want 1111", bus.CLK_OK); end
  endtask

  task automatic test_clk_stop();
    int n = 0, vis = 0, evts = 0;
    logic [1:0] prev;
    while (bus.CUR_CH !== 2'd3 && n < 100) begin @(negedge CLK); n++; end
    run[2] = 1'b0;
    prev = bus.CUR_CH; n = 0;
    while (vis < 3 && n < 300) begin
      @(negedge CLK); n++;
      if (bus.EVT === 1'b1) begin
        evts++;
        checks++; if (vis != 2 || bus.CUR_CH !== 2'd2) begin errors++; $display("FAIL stop_evt_timing got visits=%0d ch=%0d want 2/2", vis, bus.CUR_CH); end
        checks++; if (bus.CLK_OK !== 4'b1011 || bus.LOSS !== 4'b0100) begin errors++; $display("FAIL stop_evt_status got ok=%b loss=%b want 1011/0100", bus.CLK_OK, bus.LOSS); end
      end
      if (prev == 2'd2 && bus.CUR_CH == 2'd3) vis++;
      prev = bus.CUR_CH;
    end
    checks++; if (evts != 1) begin errors++; $display("FAIL stop_evt_count got %0d want 1", evts); end
    checks++; if (bus.CLK_OK !== 4'b1011 || bus.LOSS !== 4'b0100) begin errors++; $display("FAIL stop_status got ok=%b loss=%b want 1011/0100", bus.CLK_OK, bus.LOSS); end
    run[2] = 1'b1;
    n = 0; vis = 0; prev = bus.CUR_CH;
    while (vis < 1 && n < 100) begin
      @(negedge CLK); n++;
      if (prev == 2'd2 && bus.CUR_CH == 2'd3) vis++;
      prev = bus.CUR_CH;
    end
    checks++; if (bus.CLK_OK !== 4'b1111 || bus.LOSS !== 4'b0100) begin errors++; $display("FAIL restart_status got ok=%b loss=%b want 1111/0100", bus.CLK_OK, bus.LOSS); end
    bus.LOSS_CLR = 4'b0100;
    @(negedge CLK);
    bus.LOSS_CLR = 4'b0000;
    checks++; if (bus.LOSS !== 4'b0000) begin errors++; $display("FAIL loss_clr got %b want 0000", bus.LOSS); end
  endtask

  task automatic test_mask();
    int bad_cur = 0, bad_rst = 0, bad_ok = 0, rises = 0, r0 = 0, r1 = 0;
    logic seen0 = 1'b0, seen2 = 1'b0, prev;
    bus.CH_MASK = 4'b0101;
    repeat (25) @(negedge CLK);
    for (int c = 0; c < 80; c++) begin
      @(negedge CLK);
      if (bus.CUR_CH == 2'd1 || bus.CUR_CH == 2'd3) bad_cur++;
      if (!bus.DET_RST[1] || !bus.DET_RST[3]) bad_rst++;
      if (bus.CLK_OK[1] || bus.CLK_OK[3]) bad_ok++;
      if (!bus.DET_RST[0]) seen0 = 1'b1;
      if (!bus.DET_RST[2]) seen2 = 1'b1;
    end
    checks++; if (bad_cur != 0) begin errors++; $display("FAIL mask_cur_ch got %0d bad cycles want 0", bad_cur); end
    checks++; if (bad_rst != 0) begin errors++; $display("FAIL mask_det_rst got %0d bad cycles want 0", bad_rst); end
    checks++; if (bad_ok != 0) begin errors++; $display("FAIL mask_clk_ok got %0d bad cycles want 0", bad_ok); end
    checks++; if (!(seen0 && seen2)) begin errors++; $display("FAIL mask_visits got ch0=%b ch2=%b want 1/1", seen0, seen2); end
    bus.CH_MASK = 4'b0001;
    repeat (25) @(negedge CLK);
    bad_cur = 0; prev = bus.DET_RST[0];
    for (int c = 0; c < 70; c++) begin
      @(negedge CLK);
      if (bus.CUR_CH != 2'd0) bad_cur++;
      if (!prev && bus.DET_RST[0]) begin
        if (rises == 0) r0 = c; else if (rises == 1) r1 = c;
        rises++;
      end
      prev = bus.DET_RST[0];
    end
    checks++; if (bad_cur != 0) begin errors++; $display("FAIL single_cur_ch got %0d bad cycles want 0", bad_cur); end
    checks++; if (rises < 2 || r1 - r0 != 20) begin errors++; $display("FAIL single_period got %0d want 20", r1 - r0); end
    bus.CH_MASK = 4'b1111;
  endtask

  task automatic test_abort();
    int n = 0;
    logic [3:0] ok_s, loss_s;
    while (!(bus.CUR_CH == 2'd1 && bus.DET_RST[1] == 1'b0) && n < 200) begin @(negedge CLK); n++; end
    checks++; if (n >= 200) begin errors++; $display("FAIL abort_wait_timeout got %0d cycles want <200", n); end
    repeat (7) @(negedge CLK);
    ok_s = bus.CLK_OK; loss_s = bus.LOSS;
    bus.EN = 1'b0;
    @(negedge CLK);
    checks++; if (bus.BUSY !== 1'b0 || bus.DET_RST !== 4'b1111) begin errors++; $display("FAIL abort_idle got busy=%b det_rst=%b want 0/1111", bus.BUSY, bus.DET_RST); end
    checks++; if (bus.CUR_CH !== 2'd1) begin errors++; $display("FAIL abort_cur_ch got %0d want 1", bus.CUR_CH); end
    checks++; if (bus.CLK_OK !== ok_s || bus.LOSS !== loss_s) begin errors++; $display("FAIL abort_status got %b/%b want %b/%b", bus.CLK_OK, bus.LOSS, ok_s, loss_s); end
    repeat (3) @(negedge CLK);
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL abort_stay_idle got busy=%b want 0", bus.BUSY); end
    bus.EN = 1'b1;
    @(negedge CLK);
    checks++; if (bus.BUSY !== 1'b1 || bus.CUR_CH !== 2'd1) begin errors++; $display("FAIL resume_ch got busy=%b ch=%0d want 1/1", bus.BUSY, bus.CUR_CH); end
    @(negedge CLK);
    checks++; if (bus.DET_RST !== 4'b1111) begin errors++; $display("FAIL resume_arm got %b want 1111", bus.DET_RST); end
    @(negedge CLK);
    checks++; if (bus.DET_RST !== 4'b1101) begin errors++; $display("FAIL resume_wait got %b want 1101", bus.DET_RST); end
  endtask

  task automatic test_loss_collision();
    int n = 0;
    logic got = 1'b0;
    while (bus.CUR_CH !== 2'd1 && n < 100) begin @(negedge CLK); n++; end
    run[0] = 1'b0;
    bus.LOSS_CLR = 4'b0001;
    n = 0;
    while (!got && n < 300) begin
      @(negedge CLK); n++;
      if (bus.EVT === 1'b1) got = 1'b1;
    end
    checks++; if (!got || bus.CUR_CH !== 2'd0 || bus.LOSS[0] !== 1'b1) begin errors++; $display("FAIL collision_set_wins got evt=%b ch=%0d loss0=%b want 1/0/1", got, bus.CUR_CH, bus.LOSS[0]); end
    @(negedge CLK);
    checks++; if (bus.LOSS[0] !== 1'b0) begin errors++; $display("FAIL collision_then_clear got %b want 0", bus.LOSS[0]); end
    bus.LOSS_CLR = 4'b0000;
  endtask

  task automatic test_reset_midwait();
    int n = 0;
    while (bus.DET_RST === 4'b1111 && n < 100) begin @(negedge CLK); n++; end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++; if (bus.DET_RST !== 4'b1111 || bus.CLK_OK !== 4'b0000 || bus.LOSS !== 4'b0000) begin errors++; $display("FAIL midreset_status got rst=%b ok=%b loss=%b want 1111/0000/0000", bus.DET_RST, bus.CLK_OK, bus.LOSS); end
    checks++; if (bus.EVT !== 1'b0 || bus.BUSY !== 1'b0 || bus.CUR_CH !== 2'd0) begin errors++; $display("FAIL midreset_ctrl got evt=%b busy=%b ch=%0d want 0/0/0", bus.EVT, bus.BUSY, bus.CUR_CH); end
  endtask

  task automatic test_stale();
    int n = 0, wraps = 0, evts = 0;
    logic [1:0] prev;
    logic seen3 = 1'b0;
    run = 4'b0111; stale = 4'b1000;
    bus.EN = 1'b1; bus.CH_MASK = 4'b1111;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    prev = bus.CUR_CH;
    while (wraps < 3 && n < 400) begin
      @(negedge CLK); n++;
      if (bus.CUR_CH == 2'd3 && stale[3]) begin stale[3] = 1'b0; seen3 = 1'b1; end
      if (bus.EVT === 1'b1) evts++;
      if (prev == 2'd3 && bus.CUR_CH == 2'd0) begin
        wraps++;
        if (wraps == 1) begin
          checks++; if (bus.CLK_OK !== 4'b0111 || bus.LOSS !== 4'b0000) begin errors++; $display("FAIL stale_first got ok=%b loss=%b want 0111/0000", bus.CLK_OK, bus.LOSS); end
        end
      end
      prev = bus.CUR_CH;
    end
    checks++; if (!seen3 || wraps != 3) begin errors++; $display("FAIL stale_timeout got wraps=%0d want 3", wraps); end
    checks++; if (bus.LOSS !== 4'b1000 || bus.CLK_OK !== 4'b0111) begin errors++; $display("FAIL never_ok_loss got loss=%b ok=%b want 1000/0111", bus.LOSS, bus.CLK_OK); end
    checks++; if (evts != 0) begin errors++; $display("FAIL never_ok_evt got %0d want 0", evts); end
  endtask

  initial begin
    test_reset();
    test_round();
    test_clk_stop();
    test_mask();
    test_abort();
    test_loss_collision();
    test_reset_midwait();
    test_stale();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clkdet_scan_ctrl.md
Name: clkdet_scan_ctrl

Overview:
- Round-robin scheduler that shares one supervisory clock domain across NCH clock-detector cells.
- Each detector cell is a flop that sets on a monitored-clock edge and clears on its active-high reset.
- For each channel in turn, the block arms the detector (holds it in reset), opens a fixed observation window and samples the detector output through a synchronizer.
- It debounces misses and reports per-channel clock-good and sticky loss status for the clock-fail supervisor.

Parameters:
NCH, 4, number of monitored clocks / detector cells (1..16)
WINDOW, 64, CLK cycles the detector is released before sampling (>=4)
MISS_LIM, 3, consecutive missed windows before loss is declared (1..15)
RST_CYC, 2, CLK cycles detector reset is held when arming (>=2, flushes synchronizer)

Ports:
CLK  in  1  supervisory clock, all state on rising edge
RST  in  1  asynchronous, active-low reset
EN  in  1  scan enable
CH_MASK  in  NCH  1 = channel monitored
DET_Q  in  NCH  detector outputs, asynchronous to CLK
LOSS_CLR  in  NCH  per-channel clear of sticky LOSS
DET_RST  out  NCH  active-high reset to each detector cell
CLK_OK  out  NCH  channel currently judged running
LOSS  out  NCH  sticky loss flag
EVT  out  1  one-cycle pulse on any CLK_OK 1->0 transition
BUSY  out  1  scan in progress (state != IDLE)
CUR_CH  out  clog2(NCH) (min 1)  channel under test

Behaviour:
- Reset values (RST low, asynchronous): state IDLE, DET_RST all 1, CLK_OK 0, LOSS 0, EVT 0, BUSY 0, CUR_CH 0, miss counters 0, synchronizers 0.
- Synchronizer: DET_Q[i] passes through 2 flops. Only the synchronized value is used.
- DET_RST[i] = 0 only when i == CUR_CH and state is WAIT or SAMPLE. Otherwise it is 1, including for masked channels.
- FSM states and transitions:
  - IDLE -> ARM when EN=1 and CH_MASK != 0. CUR_CH is set to the lowest set mask bit at or above CUR_CH, wrapping.
  - ARM: RST_CYC cycles, then -> WAIT.
  - WAIT: WINDOW cycles counted, then -> SAMPLE.
  - SAMPLE: 1 cycle, status update, then -> NEXT.
  - NEXT: 1 cycle. CUR_CH <= next set mask bit strictly after CUR_CH, wrapping; a single-bit mask reselects the same channel. Then -> ARM, or -> IDLE if EN=0 or the mask is all 0.
- Per-channel period = RST_CYC + WINDOW + 2 cycles.
- SAMPLE update, hit (synchronized Q = 1):
  - miss_cnt <= 0
  - CLK_OK <= 1
- SAMPLE update, miss (synchronized Q = 0):
  - miss_cnt saturating increment
  - when the new count == MISS_LIM: CLK_OK <= 0 and LOSS <= 1
  - EVT pulses in the cycle after SAMPLE only if CLK_OK was 1
  - a channel that never reached OK sets LOSS but does not pulse EVT
- LOSS is sticky.
  - Cleared only by LOSS_CLR[i]=1.
  - Set wins over clear in the same cycle.
  - A later hit does not clear LOSS.
- EN deasserted in ARM/WAIT/SAMPLE: abort to IDLE next cycle, no status update, DET_RST all 1.
- CH_MASK[CUR_CH] cleared mid-check: abort to NEXT, no update.
- A masked channel at any time: CLK_OK 0, miss_cnt 0. LOSS is retained.
- Mask changes take effect at the next NEXT/IDLE decision.
- Multiple EVT sources cannot coincide: one channel is sampled per SAMPLE.

Test Plan:
Default config for all scenarios: NCH=4, WINDOW=16, MISS_LIM=3, RST_CYC=2.
1. Reset, EN=1, mask=4'b1111, all DET_Q toggling -> CUR_CH sequence 0,1,2,3,0. Period 20 cycles. DET_RST[CUR_CH] low for exactly 17 cycles each. CLK_OK=4'b1111 after first full round.
2. Channel 2 stops after OK -> CLK_OK[2] falls at 3rd consecutive miss (3 rounds, 240 cycles). EVT one pulse. LOSS[2]=1. Restart clock -> CLK_OK[2]=1 next visit, LOSS[2] stays 1 until LOSS_CLR[2].
3. mask=4'b0101 -> only channels 0,2 visited. DET_RST[1], DET_RST[3] held 1. CLK_OK[1], CLK_OK[3]=0. mask=4'b0001 -> channel 0 rescanned every 20 cycles.
4. EN dropped at WAIT cycle 8 on channel 1 -> IDLE next cycle, BUSY=0, status unchanged. Re-enable resumes at channel 1.
5. LOSS_CLR[0]=1 in same cycle LOSS[0] sets -> LOSS[0]=1. RST low mid-WAIT -> all outputs at reset values immediately.
6. DET_Q[3] high only before arming (stale) and no edges in window -> counted as miss (synchronizer flushed by ARM).
